mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-port unified instruction/data memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store from the decoded memread/memwrite controls). It grants one requester at a time, holds the transaction until the memory acknowledges, returns read data to the winner, and drives the pipeline-wide stall. Data accesses win by default; a starvation guard forces an instruction fetch through after a bounded run of data grants.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits (≥1)
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- if_req_i  in  1  fetch request, held until if_done_o
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched instruction, valid with if_done_o
- if_done_o  out  1  one-cycle completion pulse
- d_req_i  in  1  data request, held until d_done_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_rdata_o  out  DATA_W  load data, valid with d_done_o
- d_done_o  out  1  one-cycle completion pulse
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
- mem_ack_i  in  1  memory completion, single cycle, any latency ≥1 cycle after mem_req_o rises
- stall_o  out  1  freeze pipeline
- stall_cnt_o  out  32  saturating count of stalled cycles

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: eligible requester = req high and its done_o not high this cycle (masks the just-served requester). If only one eligible, grant it. If both: grant D unless starve_cnt == STARVE_LIMIT, then grant I. Grant latches addr/we/wdata into registers; next state BUSY_I/BUSY_D.
- BUSY_x: mem_req_o = 1, mem_addr_o/mem_we_o/mem_wdata_o from latched registers (mem_we_o = 0 in BUSY_I). Requester input changes after grant are ignored. On mem_ack_i: capture mem_rdata_i into the winner's rdata register, pulse the winner's done_o next cycle, go IDLE.
- starve_cnt: on D grant while if_req_i high, increment (saturate at STARVE_LIMIT); on I grant, or D grant with if_req_i low, clear to 0.
- if_rdata_o/d_rdata_o hold their last captured value until the next completion for that port; stores leave d_rdata_o unchanged.
- stall_o = (if_req_i & ~if_done_o) | (d_req_i & ~d_done_o), combinational.
- stall_cnt_o increments every cycle stall_o = 1, saturates at 0xFFFFFFFF.
- mem_ack_i in IDLE is ignored.

## Timing
- Reset (async, immediate): state IDLE, mem_req_o/mem_we_o 0, mem_addr_o/mem_wdata_o 0, both done_o 0, both rdata_o 0, starve_cnt 0, stall_cnt_o 0. Reset mid-transaction abandons it; no done_o is issued.
- Cycle 0: req seen in IDLE → cycle 1: mem_req_o high. Ack in cycle N → cycle N+1: done_o high for exactly one cycle, rdata valid, state IDLE. Zero-wait memory (ack in cycle 1): done_o in cycle 2; minimum 3 cycles from request to done.
- Back-to-back: a different eligible requester may be granted in the done_o cycle, so mem_req_o is low for exactly one cycle between transactions.
- Requester must drop or change req in the cycle its done_o is high; a request still held in the following cycle is a new transaction.

## Test plan
- Single fetch, if_addr_i = 0x40, ack 3 cycles after mem_req_o → mem_req_o high 3 cycles, mem_we_o 0, if_done_o one pulse, if_rdata_o = mem_rdata_i, stall_o high until done.
- Simultaneous if_req_i and d_req_i (store, d_addr_i = 0x100, d_wdata_i = 0xDEADBEEF) → data first with mem_we_o 1, mem_wdata_o 0xDEADBEEF; fetch granted in the d_done_o cycle.
- Starvation: if_req_i held, d_req_i re-raised after each done, STARVE_LIMIT = 4 → exactly 4 data grants, then fetch granted, starve_cnt 0 afterward.
- Input change after grant: d_addr_i changed to 0x200 during BUSY_D → mem_addr_o stays at the granted 0x100.
- Reset asserted during BUSY_D before ack → mem_req_o 0 immediately, no d_done_o, stall_cnt_o 0; new request after release serviced normally.
- Stall counter: 10 stalled cycles across two transactions → stall_cnt_o = 10; force count to 0xFFFFFFFE plus 3 stall cycles → holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates the unified single-port memory between fetch (IF) and load/store (MEM); data wins unless a fetch has waited STARVE_LIMIT grants.
// Request-to-done is ack latency + 2 cycles; requesters are held off via stall_o until their done_o pulse.
module mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_done_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_done_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i,
   output logic              stall_o,
   output logic [31:0]       stall_cnt_o
);

   localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SC_W-1:0] LIMIT = SC_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              if_done_q, if_done_d;
   logic              d_done_q, d_done_d;
   logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
   logic [31:0]       stall_cnt_q, stall_cnt_d;
   logic              if_elig, d_elig;

   // A requester whose done pulse is showing this cycle is finishing, not asking again.
   assign if_elig = if_req_i & ~if_done_q;
   assign d_elig  = d_req_i & ~d_done_q;
   assign stall_o = (if_req_i & ~if_done_q) | (d_req_i & ~d_done_q);

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      if_done_d    = 1'b0;
      d_done_d     = 1'b0;
      starve_cnt_d = starve_cnt_q;
      case (state_q)
         IDLE: begin
            if (if_elig && (!d_elig || starve_cnt_q == LIMIT)) begin
               state_d      = BUSY_I;
               addr_d       = if_addr_i;
               we_d         = 1'b0;
               starve_cnt_d = '0;
            end else if (d_elig) begin
               state_d = BUSY_D;
               addr_d  = d_addr_i;
               we_d    = d_we_i;
               wdata_d = d_wdata_i;
               if (!if_req_i)
                  starve_cnt_d = '0;
               else if (starve_cnt_q != LIMIT)
                  starve_cnt_d = starve_cnt_q + SC_W'(1);
            end
         end
         BUSY_I: begin
            if (mem_ack_i) begin
               if_rdata_d = mem_rdata_i;
               if_done_d  = 1'b1;
               state_d    = IDLE;
            end
         end
         BUSY_D: begin
            if (mem_ack_i) begin
               if (!we_q)
                  d_rdata_d = mem_rdata_i;
               d_done_d = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_o && stall_cnt_q != '1)
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
         if_done_q    <= 1'b0;
         d_done_q     <= 1'b0;
         starve_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
         if_done_q    <= if_done_d;
         d_done_q     <= d_done_d;
         starve_cnt_q <= starve_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign mem_req_o   = (state_q != IDLE);
   assign mem_we_o    = (state_q == BUSY_D) & we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign if_rdata_o  = if_rdata_q;
   assign d_rdata_o   = d_rdata_q;
   assign if_done_o   = if_done_q;
   assign d_done_o    = d_done_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays both pipeline stages and the memory by hand.
module tb_mem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_rdata_o;
   logic        if_done_o;
   logic        d_req_i;
   logic        d_we_i;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic [31:0] d_rdata_o;
   logic        d_done_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;
   logic        stall_o;
   logic [31:0] stall_cnt_o;

   int errors = 0;
   int checks = 0;
   int n;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_done_o(if_done_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_rdata_o(d_rdata_o), .d_done_o(d_done_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
      .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit past the next rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Called in the first busy cycle; acks in the lat-th busy cycle and returns in the done cycle.
   task automatic serve(input int lat, input logic [31:0] rd, output int hi);
      hi = 0;
      for (int i = 1; i <= lat; i++) begin
         if (mem_req_o) hi++;
         if (i == lat) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = rd;
         end
         tick();
         mem_ack_i = 1'b0;
      end
   endtask

   initial begin
      rst_i = 1'b1;
      if_req_i = 1'b0; if_addr_i = '0;
      d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
      mem_rdata_i = '0; mem_ack_i = 1'b0;
      #2;
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_mem_we", mem_we_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_mem_wdata", mem_wdata_o, 0);
      chk("rst_if_done", if_done_o, 0);
      chk("rst_d_done", d_done_o, 0);
      chk("rst_if_rdata", if_rdata_o, 0);
      chk("rst_d_rdata", d_rdata_o, 0);
      chk("rst_stall_cnt", stall_cnt_o, 0);
      tick(); tick();
      rst_i = 1'b0;
      tick();

      // Single fetch, ack in the third busy cycle.
      if_req_i = 1'b1; if_addr_i = 32'h40;
      #1;
      chk("f_stall_c0", stall_o, 1);
      chk("f_req_c0", mem_req_o, 0);
      tick();
      chk("f_req_c1", mem_req_o, 1);
      chk("f_we_c1", mem_we_o, 0);
      chk("f_addr_c1", mem_addr_o, 32'h40);
      serve(3, 32'hCAFE0040, n);
      chk("f_req_cycles", n, 3);
      chk("f_done", if_done_o, 1);
      chk("f_rdata", if_rdata_o, 32'hCAFE0040);
      chk("f_req_done_cyc", mem_req_o, 0);
      chk("f_stall_done_cyc", stall_o, 0);
      chk("f_stall_cnt", stall_cnt_o, 4);
      if_req_i = 1'b0;
      tick();
      chk("f_done_pulse", if_done_o, 0);
      chk("f_no_regrant", mem_req_o, 0);

      // Load with 5-cycle ack: 6 more stall cycles, 10 in total.
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h80;
      tick();
      chk("l_addr", mem_addr_o, 32'h80);
      serve(5, 32'h12345678, n);
      chk("l_req_cycles", n, 5);
      chk("l_done", d_done_o, 1);
      chk("l_rdata", d_rdata_o, 32'h12345678);
      chk("l_if_rdata_hold", if_rdata_o, 32'hCAFE0040);
      chk("l_stall_cnt10", stall_cnt_o, 10);
      d_req_i = 1'b0;
      tick();
      chk("l_done_pulse", d_done_o, 0);
      chk("l_stall_cnt_hold", stall_cnt_o, 10);

      // Simultaneous store and fetch; data first, inputs changed during BUSY_D.
      if_req_i = 1'b1; if_addr_i = 32'h300;
      d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h100; d_wdata_i = 32'hDEADBEEF;
      tick();
      chk("s_we", mem_we_o, 1);
      chk("s_addr", mem_addr_o, 32'h100);
      chk("s_wdata", mem_wdata_o, 32'hDEADBEEF);
      d_addr_i = 32'h200; d_wdata_i = 32'h0; d_we_i = 1'b0;
      tick();
      chk("s_addr_latched", mem_addr_o, 32'h100);
      chk("s_wdata_latched", mem_wdata_o, 32'hDEADBEEF);
      chk("s_we_latched", mem_we_o, 1);
      mem_ack_i = 1'b1; mem_rdata_i = 32'hAAAAAAAA;
      tick();
      mem_ack_i = 1'b0;
      chk("s_done", d_done_o, 1);
      chk("s_store_keeps_rdata", d_rdata_o, 32'h12345678);
      chk("s_gap", mem_req_o, 0);
      d_req_i = 1'b0;
      tick();
      chk("s_fetch_req", mem_req_o, 1);
      chk("s_fetch_we", mem_we_o, 0);
      chk("s_fetch_addr", mem_addr_o, 32'h300);
      mem_ack_i = 1'b1; mem_rdata_i = 32'h00000300;
      tick();
      mem_ack_i = 1'b0;
      chk("s_fetch_done", if_done_o, 1);
      chk("s_fetch_rdata", if_rdata_o, 32'h300);
      if_req_i = 1'b0;
      tick();

      // Starvation guard: both contend each round; the fetch side only drops while
      // the data done pulse is showing so it cannot slip in unopposed.
      if_addr_i = 32'h600; d_addr_i = 32'h500; d_we_i = 1'b0;
      for (int r = 0; r < 5; r++) begin
         if_req_i = 1'b1; d_req_i = 1'b1;
         tick();
         chk("starve_grant", mem_addr_o, (r < 4) ? 32'h500 : 32'h600);
         mem_ack_i = 1'b1; mem_rdata_i = r;
         tick();
         mem_ack_i = 1'b0;
         if_req_i = 1'b0; d_req_i = 1'b0;
         tick();
      end
      chk("starve_cnt_clear", 32'(dut.starve_cnt_q), 0);
      chk("starve_d_rdata", d_rdata_o, 3);
      chk("starve_if_rdata", if_rdata_o, 4);

      // Stray ack while idle is ignored.
      mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF0000;
      tick();
      mem_ack_i = 1'b0;
      chk("idle_ack_if_done", if_done_o, 0);
      chk("idle_ack_d_done", d_done_o, 0);
      chk("idle_ack_d_rdata", d_rdata_o, 3);
      chk("idle_ack_req", mem_req_o, 0);

      // Reset in the middle of a data transaction.
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h100;
      tick();
      tick();
      chk("r_busy", mem_req_o, 1);
      rst_i = 1'b1;
      #1;
      chk("r_req_now", mem_req_o, 0);
      chk("r_stall_cnt", stall_cnt_o, 0);
      chk("r_addr", mem_addr_o, 0);
      chk("r_d_rdata", d_rdata_o, 0);
      d_req_i = 1'b0;
      tick();
      chk("r_no_done", d_done_o, 0);
      rst_i = 1'b0;
      tick();
      chk("r_no_done2", d_done_o, 0);
      d_req_i = 1'b1; d_addr_i = 32'h104;
      tick();
      chk("r_new_req", mem_req_o, 1);
      chk("r_new_addr", mem_addr_o, 32'h104);
      serve(2, 32'h0BADF00D, n);
      chk("r_new_done", d_done_o, 1);
      chk("r_new_rdata", d_rdata_o, 32'h0BADF00D);
      d_req_i = 1'b0;
      tick();

      // Stall counter saturation from a preloaded near-full value.
      force dut.stall_cnt_d = 32'hFFFFFFFE;
      tick();
      release dut.stall_cnt_d;
      #1;
      chk("sat_preload", stall_cnt_o, 32'hFFFFFFFE);
      d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h10; d_wdata_i = 32'h1;
      tick();
      chk("sat_first", stall_cnt_o, 32'hFFFFFFFF);
      serve(2, 32'h0, n);
      chk("sat_done", d_done_o, 1);
      chk("sat_hold", stall_cnt_o, 32'hFFFFFFFF);
      d_req_i = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
